// File: rtl/fft_r4_16p_pkg.sv
// Shared types and constants for the 16-point radix-4 single-path FFT sequencer.
package fft_r4_16p_pkg;

  localparam int N_POINTS = 16;
  localparam int RADIX    = 4;
  localparam int PHASE_W  = $clog2(N_POINTS);
  localparam int SEL_W    = $clog2(RADIX);

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    EMIT
  } state_t;

endpackage

// File: rtl/fft_r4_16p_seq_phase_cnt.sv
// Datapath phase counter: one step per datapath advance, synchronous clear wins over enable.
module fft_phase_cnt
  import fft_r4_16p_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   clr,
  output phase_t phase
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + phase_t'(1);
    end
  end

endmodule

// File: rtl/fft_r4_16p_seq.sv
// Control sequencer for a 16-point radix-4 SDF FFT: sample load, pipeline flush, output emit.
module fft_r4_16p_seq
  import fft_r4_16p_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int FCNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              pipe_en,
  output sel_t              sel_q,
  output sel_t              sel_m,
  output logic              out_valid,
  output sel_t              out_idx,
  output logic              frame_done,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int               LAT_W      = 4;
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(LATENCY - 1);
  localparam phase_t           PHASE_LAST = phase_t'(N_POINTS - 1);
  localparam sel_t             IDX_LAST   = sel_t'(RADIX - 1);

  state_t           state;
  logic             armed;
  logic [LAT_W-1:0] lat_cnt;
  phase_t           phase;
  logic             accept;
  logic             phase_en;
  logic             phase_clr;
  logic             last_group;

  // armed keeps in_ready low until the first clock edge after reset releases
  assign in_ready   = ((state == IDLE) && armed) || (state == LOAD);
  assign accept     = in_valid & in_ready;
  assign last_group = (state == EMIT) && (out_idx == IDX_LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pipe_en = 1'b0;
    case (state)
      IDLE:        pipe_en = 1'b0;
      LOAD:        pipe_en = accept;
      FLUSH, EMIT: pipe_en = 1'b1;
      default:     pipe_en = 1'b0;
    endcase
    if (abort) pipe_en = 1'b0;
  end

  // The first sample is accepted in IDLE without a datapath advance, but still counts a phase step
  assign phase_en  = pipe_en | ((state == IDLE) & accept & ~abort);
  assign phase_clr = abort | last_group;

  fft_phase_cnt u_phase_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (phase_en),
    .clr   (phase_clr),
    .phase (phase)
  );

  assign sel_q      = phase[SEL_W-1:0];
  assign sel_m      = phase[PHASE_W-1:SEL_W];
  assign out_valid  = (state == EMIT);
  assign frame_done = last_group & ~abort;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      armed     <= 1'b0;
      lat_cnt   <= '0;
      out_idx   <= '0;
      frame_cnt <= '0;
    end else begin
      armed <= 1'b1;
      if (abort) begin
        state   <= IDLE;
        lat_cnt <= '0;
        out_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) state <= LOAD;
          end
          LOAD: begin
            if (accept && (phase == PHASE_LAST)) begin
              state   <= FLUSH;
              lat_cnt <= '0;
            end
          end
          FLUSH: begin
            lat_cnt <= lat_cnt + LAT_W'(1);
            if (lat_cnt == LAT_LAST) state <= EMIT;
          end
          EMIT: begin
            out_idx <= out_idx + sel_t'(1);
            if (out_idx == IDX_LAST) begin
              state     <= IDLE;
              frame_cnt <= frame_cnt + FCNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_r4_16p_seq.sv
// Directed bench for fft_r4_16p_seq; instances with LATENCY 8, 1 and 15 share one stimulus.
module tb_fft_r4_16p_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic abort = 1'b0;

  // index 0: LATENCY=8, index 1: LATENCY=1, index 2: LATENCY=15
  logic       rdy[3], pe[3], ov[3], fd[3], bsy[3];
  logic [1:0] sq[3], sm[3], oi[3];
  logic [7:0] fc[3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_r4_16p_seq #(.LATENCY(8), .FCNT_W(8)) dut_l8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .abort(abort),
    .pipe_en(pe[0]), .sel_q(sq[0]), .sel_m(sm[0]), .out_valid(ov[0]), .out_idx(oi[0]),
    .frame_done(fd[0]), .busy(bsy[0]), .frame_cnt(fc[0]));

  fft_r4_16p_seq #(.LATENCY(1), .FCNT_W(8)) dut_l1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .abort(abort),
    .pipe_en(pe[1]), .sel_q(sq[1]), .sel_m(sm[1]), .out_valid(ov[1]), .out_idx(oi[1]),
    .frame_done(fd[1]), .busy(bsy[1]), .frame_cnt(fc[1]));

  fft_r4_16p_seq #(.LATENCY(15), .FCNT_W(8)) dut_l15 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]), .abort(abort),
    .pipe_en(pe[2]), .sel_q(sq[2]), .sel_m(sm[2]), .out_valid(ov[2]), .out_idx(oi[2]),
    .frame_done(fd[2]), .busy(bsy[2]), .frame_cnt(fc[2]));

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({rdy[0], pe[0], ov[0], fd[0], bsy[0], oi[0], sm[0], sq[0], fc[0]} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b required all zero",
               {rdy[0], pe[0], ov[0], fd[0], bsy[0], oi[0], sm[0], sq[0], fc[0]});
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({rdy[0], bsy[0], pe[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release ready/busy/pipe_en got %b required 100", {rdy[0], bsy[0], pe[0]});
    end
  endtask

  task automatic test_continuous();
    logic [18:0] obs, exp_v;
    logic [3:0]  ph;
    do_reset();
    in_valid = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      ph    = (k <= 28) ? 4'((k - 1) % 16) : 4'd0;
      exp_v = {((k <= 16) || (k >= 29)), ((k >= 2) && (k <= 28)), ((k >= 25) && (k <= 28)),
               (k == 28), ((k >= 2) && (k <= 28)),
               ((k >= 25) && (k <= 28)) ? 2'(k - 25) : 2'd0, ph, (k >= 29) ? 8'd1 : 8'd0};
      obs   = {rdy[0], pe[0], ov[0], fd[0], bsy[0], oi[0], sm[0], sq[0], fc[0]};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL continuous cycle=%0d rdy,pe,ov,fd,busy,idx,sel_m,sel_q,cnt got %b required %b",
                 k, obs, exp_v);
      end
      @(posedge clk); #1;
      in_valid = (k + 1 <= 16);
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k >= 6 && k <= 9) begin
        n_tests++;
        if ({pe[0], sm[0], sq[0]} !== {(k == 9), 4'd5}) begin
          n_fail++;
          $display("FAIL stall_hold cycle=%0d pipe_en,phase got %b required %b",
                   k, {pe[0], sm[0], sq[0]}, {(k == 9), 4'd5});
        end
      end
      n_tests++;
      if ({ov[0], fd[0]} !== {((k >= 28) && (k <= 31)), (k == 31)}) begin
        n_fail++;
        $display("FAIL stall_window cycle=%0d out_valid,frame_done got %b required %b",
                 k, {ov[0], fd[0]}, {((k >= 28) && (k <= 31)), (k == 31)});
      end
      @(posedge clk); #1;
      in_valid = (k + 1 <= 5) || ((k + 1 >= 9) && (k + 1 <= 19));
    end
    n_tests++;
    if (fc[0] !== 8'd1) begin
      n_fail++; $display("FAIL stall_frame_cnt got %0d required 1", fc[0]);
    end
  endtask

  task automatic test_abort_flush();
    logic seen_ov, seen_fd;
    seen_ov = 1'b0; seen_fd = 1'b0;
    do_reset();
    in_valid = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 20) begin
        n_tests++;
        if ({bsy[0], pe[0]} !== 2'b10) begin
          n_fail++; $display("FAIL abort_flush_cycle busy,pipe_en got %b required 10", {bsy[0], pe[0]});
        end
      end
      if (k == 21) begin
        n_tests++;
        if ({bsy[0], rdy[0], sm[0], sq[0]} !== 6'b010000) begin
          n_fail++;
          $display("FAIL abort_flush_idle busy,rdy,phase got %b required 010000",
                   {bsy[0], rdy[0], sm[0], sq[0]});
        end
      end
      seen_ov |= ov[0];
      seen_fd |= fd[0];
      @(posedge clk); #1;
      in_valid = (k + 1 <= 16);
      abort    = (k + 1 == 20);
    end
    n_tests++;
    if ({seen_ov, seen_fd, fc[0]} !== 10'b0) begin
      n_fail++;
      $display("FAIL abort_flush_quiet out_valid_seen,frame_done_seen,cnt got %b required 0",
               {seen_ov, seen_fd, fc[0]});
    end
    in_valid = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      n_tests++;
      if ({ov[0], fd[0]} !== {((k >= 25) && (k <= 28)), (k == 28)}) begin
        n_fail++;
        $display("FAIL abort_next_frame cycle=%0d out_valid,frame_done got %b required %b",
                 k, {ov[0], fd[0]}, {((k >= 25) && (k <= 28)), (k == 28)});
      end
      @(posedge clk); #1;
      in_valid = (k + 1 <= 16);
    end
    n_tests++;
    if (fc[0] !== 8'd1) begin
      n_fail++; $display("FAIL abort_next_cnt got %0d required 1", fc[0]);
    end
  endtask

  task automatic test_abort_accept();
    do_reset();
    in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) begin
        n_tests++;
        if ({sm[0], sq[0]} !== 4'd2) begin
          n_fail++; $display("FAIL abort_accept_load phase got %0d required 2", {sm[0], sq[0]});
        end
      end
      if (k == 4) begin
        n_tests++;
        if ({pe[0], rdy[0]} !== 2'b01) begin
          n_fail++; $display("FAIL abort_accept_drop pipe_en,rdy got %b required 01", {pe[0], rdy[0]});
        end
      end
      if (k == 5) begin
        n_tests++;
        if ({bsy[0], pe[0], rdy[0], sm[0], sq[0]} !== 7'b0010000) begin
          n_fail++;
          $display("FAIL abort_accept_idle busy,pe,rdy,phase got %b required 0010000",
                   {bsy[0], pe[0], rdy[0], sm[0], sq[0]});
        end
      end
      @(posedge clk); #1;
      in_valid = (k + 1 <= 4);
      abort    = (k + 1 == 4);
    end
  endtask

  task automatic test_reset_emit();
    logic seen_fd;
    seen_fd = 1'b0;
    do_reset();
    in_valid = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 26) break;
      @(posedge clk); #1;
      in_valid = (k + 1 <= 16);
    end
    n_tests++;
    if ({ov[0], oi[0]} !== 3'b101) begin
      n_fail++; $display("FAIL reset_emit_pre out_valid,idx got %b required 101", {ov[0], oi[0]});
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({rdy[0], pe[0], ov[0], fd[0], bsy[0], oi[0], sm[0], sq[0], fc[0]} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_emit_async got %b required all zero",
               {rdy[0], pe[0], ov[0], fd[0], bsy[0], oi[0], sm[0], sq[0], fc[0]});
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen_fd |= fd[0];
      @(posedge clk); #1;
      if (k == 3) reset = 1'b1;
    end
    n_tests++;
    if ({seen_fd, fc[0]} !== 9'b0) begin
      n_fail++; $display("FAIL reset_emit_done frame_done_seen,cnt got %b required 0", {seen_fd, fc[0]});
    end
  endtask

  task automatic test_latency_windows();
    int first_v[3], n_v[3], done_c[3];
    int e_first;
    for (int i = 0; i < 3; i++) begin
      first_v[i] = 0; n_v[i] = 0; done_c[i] = 0;
    end
    do_reset();
    in_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (ov[i]) begin
          if (first_v[i] == 0) first_v[i] = k;
          n_v[i]++;
        end
        if (fd[i] && oi[i] == 2'd3) done_c[i] = k;
      end
      @(posedge clk); #1;
      in_valid = (k + 1 <= 16);
    end
    for (int i = 0; i < 3; i++) begin
      e_first = (i == 0) ? 25 : (i == 1) ? 18 : 32;
      n_tests++;
      if (first_v[i] != e_first || n_v[i] != 4 || done_c[i] != e_first + 3 || fc[i] !== 8'd1) begin
        n_fail++;
        $display("FAIL latency_window inst=%0d first,count,done,cnt got %0d,%0d,%0d,%0d required %0d,4,%0d,1",
                 i, first_v[i], n_v[i], done_c[i], fc[i], e_first, e_first + 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic got;
    int   prev;
    prev = 0;
    do_reset();
    in_valid = 1'b1;
    for (int f = 0; f < 256; f++) begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (fd[0]) got = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL b2b_timeout frame=%0d got no frame_done in 40 cycles required one", f);
        break;
      end
      n_tests++;
      if (fc[0] !== 8'(f)) begin
        n_fail++; $display("FAIL b2b_cnt frame=%0d got %0d required %0d", f, fc[0], f);
      end
      if (f > 0) begin
        n_tests++;
        if (cyc - prev != 28) begin
          n_fail++; $display("FAIL b2b_period frame=%0d got %0d required 28", f, cyc - prev);
        end
      end
      prev = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (fc[0] !== 8'd0) begin
      n_fail++; $display("FAIL b2b_wrap got %0d required 0", fc[0]);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_stall();
    test_abort_flush();
    test_abort_accept();
    test_reset_emit();
    test_latency_windows();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion by 1ms required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft_r4_16p_seq.md
FFT_R4_16P_SEQ -- requirements
Module: fft_r4_16p_seq

Interface
REQ-001 Parameter LATENCY, default 8, is the number of pipe_en cycles from the 16th accepted sample to the first valid output group; legal range 1..15.
REQ-002 Parameter FCNT_W, default 8, is the width of the frame counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream sample (real/imag pair) present this cycle.
REQ-006 in_ready  output  1  block accepts a sample this cycle; accept = in_valid & in_ready.
REQ-007 abort  input  1  synchronous frame abort; returns the block to IDLE.
REQ-008 pipe_en  output  1  datapath advance enable for delay lines and commutators.
REQ-009 sel_q  output  2  stage-1 butterfly/commutator select.
REQ-010 sel_m  output  2  stage-2 commutator mux select.
REQ-011 out_valid  output  1  the four butterfly-2 outputs hold a valid group this cycle.
REQ-012 out_idx  output  2  index of the current output group, 0..3.
REQ-013 frame_done  output  1  one-cycle pulse with the last output group (out_idx=3).
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_cnt  output  FCNT_W  count of completed frames; wraps modulo 2^FCNT_W.

Function
REQ-016 States: IDLE, LOAD, FLUSH and EMIT.
REQ-017 IDLE: in_ready=1, pipe_en=0; the first accept moves the FSM to LOAD with phase=1.
REQ-018 A 4-bit phase counter increments on every pipe_en cycle; sel_q=phase[1:0] and sel_m=phase[3:2], both combinational from phase.
REQ-019 LOAD: in_ready=1; pipe_en equals accept; phase holds when in_valid=0 (stall, no timeout).
REQ-020 LOAD: the accept that sets phase to 0 (16th sample, wrap) moves the FSM to FLUSH and clears the latency counter.
REQ-021 FLUSH: in_ready=0, pipe_en=1; the latency counter increments each cycle, and the FSM moves to EMIT when the counter reaches LATENCY-1.
REQ-022 EMIT: in_ready=0, pipe_en=1, out_valid=1, out_idx=0,1,2,3 on 4 consecutive cycles.
REQ-023 frame_done pulses high in the out_idx=3 cycle; frame_cnt increments at the end of that cycle.
REQ-024 EMIT exit: the FSM goes to IDLE after out_idx=3; the first accept of the next frame occurs no earlier than the following cycle.
REQ-025 Minimum frame period: 16+LATENCY+4 cycles from the first accept to the last out_valid cycle when there are no stalls.
REQ-026 abort in any state: next state IDLE, phase=0, counters=0, out_valid=0; frame_cnt is unchanged and there is no frame_done pulse.
REQ-027 abort coincident with an accept: abort wins, and the sample is dropped (pipe_en=0 that cycle).
REQ-028 out_valid, frame_done and in_ready are mutually consistent: in_ready=1 never coincides with out_valid=1.

Reset
REQ-029 While reset=0: state=IDLE, phase=0, latency counter=0, out_idx=0, frame_cnt=0.
REQ-030 While reset=0, the outputs are: pipe_en=0, out_valid=0, frame_done=0, busy=0, sel_q=0, sel_m=0, in_ready=0.
REQ-031 in_ready rises in the first clk cycle after reset deasserts.
REQ-032 Reset asserted mid-frame discards the frame with no frame_done pulse.
REQ-033 Reset deassertion is synchronised externally; the block does not resynchronise it.

Structure
REQ-034 A shared package holds the state enum (IDLE/LOAD/FLUSH/EMIT), the constant N_POINTS=16, the constant RADIX=4, and the 2-bit select type.
REQ-035 One sub-module, fft_phase_cnt, implements the 4-bit phase counter with enable and synchronous clear; everything else is flat.

Verification
REQ-036 Scenario: reset, then in_valid=1 continuously, LATENCY=8. Required: in_ready high for 16 cycles; sel_q sequence 0,1,2,3 repeating; sel_m steps every 4 cycles; out_valid high on cycles 25..28 after the first accept with out_idx 0..3; frame_done at out_idx 3; frame_cnt=1.
REQ-037 Scenario: in_valid=0 for 3 cycles after the 5th sample. Required: phase holds at 5, pipe_en=0 for those cycles, and the output window shifts by exactly 3 cycles.
REQ-038 Scenario: abort during FLUSH. Required: IDLE next cycle, out_valid never asserts, frame_cnt unchanged, and the next frame runs normally.
REQ-039 Scenario: abort and accept in the same LOAD cycle. Required: pipe_en=0, phase=0, IDLE.
REQ-040 Scenario: reset pulled low during EMIT at out_idx=1. Required: all outputs go to their reset values immediately (asynchronously), with no frame_done.
REQ-041 Scenario: 256 back-to-back frames with FCNT_W=8. Required: frame_cnt wraps from 255 to 0, and LATENCY=1 and LATENCY=15 each produce the correct output window.
